spram_arb: RTL
==============

SPRAM_ARB -- requirements
Module: spram_arb

Interface
REQ-001 SHALL have parameter IDLE_SB, default 16: number of consecutive idle cycles before the RAM enters standby (range 1..255).
REQ-002 SHALL have parameter WAKE_CYC, default 2: number of cycles of standby exit before the first grant (range 1..15).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 SHALL have ports a_req, input, 1 bit: requester A access request; a_we, input, 1 bit: write when 1; a_be, input, 2 bits: byte enables; a_addr, input, 14 bits: word address; a_wdata, input, 16 bits: write data.
REQ-006 SHALL have ports a_gnt, output, 1 bit: A request accepted this cycle; a_rvalid, output, 1 bit: A read data valid; a_rdata, output, 16 bits: A read data.
REQ-007 SHALL have ports b_req, b_we, b_be, b_addr, b_wdata, b_gnt, b_rvalid and b_rdata, identical in width and meaning to the A ports, for requester B.
REQ-008 SHALL have ram_ad, output, 14 bits; ram_di, output, 16 bits; ram_maskwe, output, 4 bits; ram_we, output, 1 bit; ram_cs, output, 1 bit; ram_stdby, output, 1 bit; ram_do, input, 16 bits. These connect directly to one 16Kx16 single-port RAM macro.

Function
REQ-009 SHALL implement a state machine with states ACT, STBY and WAKE.
REQ-010 In ACT, a request SHALL be granted combinationally in the same cycle: gnt=1, ram_cs=1, and ram_ad/ram_di/ram_we driven from the granted requester.
REQ-011 At most one gnt SHALL be high per cycle.
REQ-012 When a_req and b_req are both high, the grant SHALL go to the requester not granted most recently (round-robin); last-winner is updated on every grant.
REQ-013 When no requester is granted, ram_cs SHALL be 0, ram_we SHALL be 0, and ram_ad/ram_di SHALL hold their last values.
REQ-014 Mask mapping: ram_maskwe = {be[1],be[1],be[0],be[0]} of the granted requester; ram_maskwe SHALL be 0000 on reads and when idle.
REQ-015 A write with be=00 SHALL still be granted and drive ram_cs=1 with ram_maskwe=0000, leaving memory unchanged.
REQ-016 Read latency: a granted read at cycle N SHALL produce x_rvalid=1 for exactly one cycle at N+1, with x_rdata=ram_do in that cycle.
REQ-017 x_rdata SHALL be held at its last valid value while x_rvalid=0.
REQ-018 A granted write SHALL produce no rvalid.
REQ-019 Back-to-back grants SHALL be accepted every cycle, so rvalids may be asserted on consecutive cycles, including alternating A/B.
REQ-020 The idle counter (8 bits) SHALL clear on any cycle with a_req or b_req high in ACT, and otherwise increment in ACT, saturating.
REQ-021 When the idle counter equals IDLE_SB, the next state SHALL be STBY.
REQ-022 In STBY: ram_stdby=1, ram_cs=0, no grants; any req SHALL transition to WAKE on the next cycle.
REQ-023 In WAKE: ram_stdby=0, no grants, for exactly WAKE_CYC cycles, then ACT, with the idle counter cleared.
REQ-024 A req dropping during WAKE SHALL NOT abort WAKE.
REQ-025 Requests not granted SHALL be held by the requester; the block SHALL NOT queue them.
REQ-026 A pending rvalid from the last ACT cycle SHALL still be delivered when the state changes to STBY.

Reset
REQ-027 While rst_n=0 at a clk edge, the block SHALL enter ACT, clear the idle and wake counters, and set last-winner=B so that A wins the first conflict.
REQ-028 During reset, a_gnt, b_gnt, a_rvalid, b_rvalid, ram_cs, ram_we and ram_stdby SHALL be 0, and ram_maskwe, ram_ad, ram_di, a_rdata and b_rdata SHALL be 0.
REQ-029 Reset asserted mid-read SHALL drop the pending rvalid: no rvalid is asserted in the cycle after reset.

Verification
REQ-030 A writes addr 0x0123 data 0xBEEF be=11, then reads 0x0123 -> a_rvalid one cycle after the read grant, a_rdata=0xBEEF.
REQ-031 B writes 0x55AA be=01 over 0x1234 at addr 5, then reads addr 5 -> b_rdata=0x12AA and ram_maskwe=0011 during the write.
REQ-032 a_req and b_req both held high for 4 cycles right after reset -> grants A,B,A,B and never both high together.
REQ-033 No req for IDLE_SB cycles -> ram_stdby=1; then a_req=1 -> stdby=0 the next cycle, and a_gnt after WAKE_CYC further cycles.
REQ-034 rst_n=0 in the cycle after an A read grant -> a_rvalid stays 0, and all outputs are 0 during reset.

Source files
------------

// File: rtl/spram_arb.sv
// Two-requester round-robin arbiter in front of a 16Kx16 single-port RAM macro,
// with idle-driven standby entry and a fixed-length wake sequence.
module spram_arb #(
    parameter int unsigned IDLE_SB  = 16,
    parameter int unsigned WAKE_CYC = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        a_req,
    input  logic        a_we,
    input  logic [1:0]  a_be,
    input  logic [13:0] a_addr,
    input  logic [15:0] a_wdata,
    output logic        a_gnt,
    output logic        a_rvalid,
    output logic [15:0] a_rdata,
    input  logic        b_req,
    input  logic        b_we,
    input  logic [1:0]  b_be,
    input  logic [13:0] b_addr,
    input  logic [15:0] b_wdata,
    output logic        b_gnt,
    output logic        b_rvalid,
    output logic [15:0] b_rdata,
    output logic [13:0] ram_ad,
    output logic [15:0] ram_di,
    output logic [3:0]  ram_maskwe,
    output logic        ram_we,
    output logic        ram_cs,
    output logic        ram_stdby,
    input  logic [15:0] ram_do
);

    typedef enum logic [1:0] {StAct, StStby, StWake} state_t;

    localparam logic [7:0] IdleSb   = 8'(IDLE_SB);
    localparam logic [3:0] WakeLast = 4'(WAKE_CYC - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [7:0]  r_idle;
    logic [3:0]  r_wake;
    logic        r_last_b;
    logic [13:0] r_ad;
    logic [15:0] r_di;
    logic        r_a_pend;
    logic        r_b_pend;
    logic [15:0] r_a_rdata;
    logic [15:0] r_b_rdata;

    logic        w_any_req;
    logic        w_act;
    logic        w_gnt_a;
    logic        w_gnt_b;
    logic        w_we;
    logic [1:0]  w_be;

    always_comb begin
        w_any_req = a_req | b_req;
        w_act     = rst_n && (r_state == StAct);
        // A wins a conflict only when B was the most recent winner
        w_gnt_a   = w_act && a_req && (!b_req || r_last_b);
        w_gnt_b   = w_act && b_req && !w_gnt_a;
        w_we      = (w_gnt_a & a_we) | (w_gnt_b & b_we);
        w_be      = w_gnt_a ? a_be : b_be;
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            StAct:   if (r_idle == IdleSb) w_state_nxt = StStby;
            StStby:  if (w_any_req) w_state_nxt = StWake;
            StWake:  if (r_wake == WakeLast) w_state_nxt = StAct;
            default: w_state_nxt = StAct;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= StAct;
            r_idle    <= 8'd0;
            r_wake    <= 4'd0;
            r_last_b  <= 1'b1;
            r_ad      <= 14'd0;
            r_di      <= 16'd0;
            r_a_pend  <= 1'b0;
            r_b_pend  <= 1'b0;
            r_a_rdata <= 16'd0;
            r_b_rdata <= 16'd0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == StAct) begin
                if (w_any_req) begin
                    r_idle <= 8'd0;
                end else if (r_idle != 8'hFF) begin
                    r_idle <= r_idle + 8'd1;
                end
            end else if (r_state == StWake) begin
                r_idle <= 8'd0;
            end
            r_wake <= (r_state == StWake) ? r_wake + 4'd1 : 4'd0;
            if (w_gnt_a) begin
                r_last_b <= 1'b0;
                r_ad     <= a_addr;
                r_di     <= a_wdata;
            end else if (w_gnt_b) begin
                r_last_b <= 1'b1;
                r_ad     <= b_addr;
                r_di     <= b_wdata;
            end
            r_a_pend <= w_gnt_a && !a_we;
            r_b_pend <= w_gnt_b && !b_we;
            if (r_a_pend) r_a_rdata <= ram_do;
            if (r_b_pend) r_b_rdata <= ram_do;
        end
    end

    assign a_gnt      = w_gnt_a;
    assign b_gnt      = w_gnt_b;
    assign ram_cs     = w_gnt_a | w_gnt_b;
    assign ram_we     = w_we;
    assign ram_maskwe = w_we ? {w_be[1], w_be[1], w_be[0], w_be[0]} : 4'b0000;
    assign ram_ad     = !rst_n ? 14'd0 : w_gnt_a ? a_addr : w_gnt_b ? b_addr : r_ad;
    assign ram_di     = !rst_n ? 16'd0 : w_gnt_a ? a_wdata : w_gnt_b ? b_wdata : r_di;
    assign ram_stdby  = rst_n && (r_state == StStby);
    // Outputs are forced low while reset is held, so a read in flight is dropped
    assign a_rvalid   = rst_n && r_a_pend;
    assign b_rvalid   = rst_n && r_b_pend;
    assign a_rdata    = !rst_n ? 16'd0 : r_a_pend ? ram_do : r_a_rdata;
    assign b_rdata    = !rst_n ? 16'd0 : r_b_pend ? ram_do : r_b_rdata;

endmodule
